// File: rtl/hdmi_scdc_status_monitor.sv
// Periodic SCDC status poller for an HDMI 2.0 TX link. It reads the sink's update,
// scrambler, lock and error-counter registers, clears the update flags, and flags a link fault.
module hdmi_scdc_status_monitor #(
  parameter int unsigned CLOCK_FREQUENCY  = 0,
  parameter int unsigned POLL_INTERVAL_MS = 100,
  parameter logic [6:0]  SCDC_ADDRESS     = 7'h54,
  parameter int unsigned MAX_FAILURES     = 3
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        enable,
  input  logic        scrambler_expected,
  output logic        i2c_ready,
  output logic [6:0]  i2c_address,
  output logic        i2c_rw,
  output logic [7:0]  i2c_register,
  output logic [7:0]  i2c_data_write,
  input  logic        i2c_valid,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_data_read,
  output logic        status_valid,
  output logic        clock_detected,
  output logic [2:0]  ch_locked,
  output logic        scrambling_status,
  output logic [14:0] err_ch0,
  output logic [14:0] err_ch1,
  output logic [14:0] err_ch2,
  output logic        link_fault
);

  // A zero-length interval (e.g. CLOCK_FREQUENCY left at 0) degenerates to back-to-back polls.
  localparam longint unsigned POLL_CYCLES =
    (64'(CLOCK_FREQUENCY) / 64'd1000) * 64'(POLL_INTERVAL_MS);
  localparam logic [31:0] TIMER_LOAD = (POLL_CYCLES == 64'd0) ? '0 : 32'(POLL_CYCLES - 64'd1);
  localparam logic [3:0]  MAX_CNT    = 4'(MAX_FAILURES);
  localparam logic [3:0]  LAST_IDX   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CLEAR,
    S_REPORT
  } state_t;

  state_t      state_q;
  logic [31:0] timer_q;
  logic [3:0]  idx_q;
  logic [7:0]  shadow_q [9];
  logic        nack_q;
  logic [3:0]  fail_cnt_q;

  logic        ready_q;
  logic        rw_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic        status_valid_q;
  logic        clock_detected_q;
  logic [2:0]  ch_locked_q;
  logic        scrambling_status_q;
  logic [14:0] err_ch0_q;
  logic [14:0] err_ch1_q;
  logic [14:0] err_ch2_q;
  logic        link_fault_q;

  logic        clock_detected_d;
  logic [2:0]  ch_locked_d;
  logic        scrambling_status_d;
  logic [14:0] err_ch0_d;
  logic [14:0] err_ch1_d;
  logic [14:0] err_ch2_d;
  logic        bad_d;
  logic [3:0]  fail_cnt_d;
  logic [7:0]  next_reg_d;

  function automatic logic [7:0] scdc_reg(input logic [3:0] idx);
    case (idx)
      4'd0:    scdc_reg = 8'h10;
      4'd1:    scdc_reg = 8'h21;
      4'd2:    scdc_reg = 8'h40;
      4'd3:    scdc_reg = 8'h50;
      4'd4:    scdc_reg = 8'h51;
      4'd5:    scdc_reg = 8'h52;
      4'd6:    scdc_reg = 8'h53;
      4'd7:    scdc_reg = 8'h54;
      4'd8:    scdc_reg = 8'h55;
      default: scdc_reg = 8'h10;
    endcase
  endfunction

  // Shadow slots: 0=0x10, 1=0x21, 2=0x40, 3..8 = 0x50..0x55 (lo/hi per channel).
  always_comb begin
    clock_detected_d    = shadow_q[2][0];
    ch_locked_d         = shadow_q[2][3:1];
    scrambling_status_d = shadow_q[1][0];
    err_ch0_d           = shadow_q[4][7] ? {shadow_q[4][6:0], shadow_q[3]} : '0;
    err_ch1_d           = shadow_q[6][7] ? {shadow_q[6][6:0], shadow_q[5]} : '0;
    err_ch2_d           = shadow_q[8][7] ? {shadow_q[8][6:0], shadow_q[7]} : '0;
    bad_d               = nack_q | ~clock_detected_d | (ch_locked_d != 3'b111) |
                          (scrambling_status_d != scrambler_expected);
    fail_cnt_d          = '0;
    if (bad_d) begin
      fail_cnt_d = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;
    end
    next_reg_d          = scdc_reg(idx_q + 4'd1);
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q             <= S_IDLE;
      timer_q             <= '0;
      idx_q               <= '0;
      for (int unsigned i = 0; i < 9; i++) shadow_q[i] <= '0;
      nack_q              <= 1'b0;
      fail_cnt_q          <= '0;
      ready_q             <= 1'b0;
      rw_q                <= 1'b1;
      reg_q               <= '0;
      wdata_q             <= '0;
      status_valid_q      <= 1'b0;
      clock_detected_q    <= 1'b0;
      ch_locked_q         <= '0;
      scrambling_status_q <= 1'b0;
      err_ch0_q           <= '0;
      err_ch1_q           <= '0;
      err_ch2_q           <= '0;
      link_fault_q        <= 1'b0;
    end else if (!enable) begin
      // Abort: status outputs deliberately hold their last published values.
      state_q        <= S_IDLE;
      idx_q          <= '0;
      ready_q        <= 1'b0;
      rw_q           <= 1'b1;
      status_valid_q <= 1'b0;
      fail_cnt_q     <= '0;
      link_fault_q   <= 1'b0;
      nack_q         <= 1'b0;
    end else begin
      status_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= TIMER_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (timer_q == '0) begin
            ready_q <= 1'b1;
            rw_q    <= 1'b1;
            reg_q   <= scdc_reg(4'd0);
            idx_q   <= '0;
            nack_q  <= 1'b0;
            state_q <= S_READ;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_READ: begin
          if (i2c_valid) begin
            if (i2c_nack) begin
              ready_q <= 1'b0;
              nack_q  <= 1'b1;
              state_q <= S_REPORT;
            end else begin
              shadow_q[idx_q] <= i2c_data_read;
              if (idx_q == LAST_IDX) begin
                // Writing back the flags just read clears exactly those update bits.
                rw_q    <= 1'b0;
                reg_q   <= 8'h10;
                wdata_q <= shadow_q[0];
                state_q <= S_CLEAR;
              end else begin
                idx_q <= idx_q + 4'd1;
                reg_q <= next_reg_d;
              end
            end
          end
        end
        S_CLEAR: begin
          if (i2c_valid) begin
            ready_q <= 1'b0;
            rw_q    <= 1'b1;
            nack_q  <= i2c_nack;
            state_q <= S_REPORT;
          end
        end
        S_REPORT: begin
          status_valid_q <= 1'b1;
          if (!nack_q) begin
            clock_detected_q    <= clock_detected_d;
            ch_locked_q         <= ch_locked_d;
            scrambling_status_q <= scrambling_status_d;
            err_ch0_q           <= err_ch0_d;
            err_ch1_q           <= err_ch1_d;
            err_ch2_q           <= err_ch2_d;
          end
          fail_cnt_q <= fail_cnt_d;
          if (fail_cnt_d >= MAX_CNT) link_fault_q <= 1'b1;
          nack_q  <= 1'b0;
          timer_q <= TIMER_LOAD;
          state_q <= S_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i2c_ready         = ready_q;
  assign i2c_address       = SCDC_ADDRESS;
  assign i2c_rw            = rw_q;
  assign i2c_register      = reg_q;
  assign i2c_data_write    = wdata_q;
  assign status_valid      = status_valid_q;
  assign clock_detected    = clock_detected_q;
  assign ch_locked         = ch_locked_q;
  assign scrambling_status = scrambling_status_q;
  assign err_ch0           = err_ch0_q;
  assign err_ch1           = err_ch1_q;
  assign err_ch2           = err_ch2_q;
  assign link_fault        = link_fault_q;

endmodule

// File: tb/tb_hdmi_scdc_status_monitor.sv
// Bench for hdmi_scdc_status_monitor: an SCDC sink responder with random register contents,
// latency and NACKs, checked against a poll-level reference model.
module tb_hdmi_scdc_status_monitor;
  localparam int unsigned MAXF = 3;

  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic        enable = 1'b0;
  logic        scrambler_expected = 1'b0;
  logic        i2c_ready;
  logic [6:0]  i2c_address;
  logic        i2c_rw;
  logic [7:0]  i2c_register;
  logic [7:0]  i2c_data_write;
  logic        i2c_valid = 1'b0;
  logic        i2c_nack = 1'b0;
  logic [7:0]  i2c_data_read = '0;
  logic        status_valid;
  logic        clock_detected;
  logic [2:0]  ch_locked;
  logic        scrambling_status;
  logic [14:0] err_ch0;
  logic [14:0] err_ch1;
  logic [14:0] err_ch2;
  logic        link_fault;

  always #5 clk = ~clk;

  hdmi_scdc_status_monitor #(
    .CLOCK_FREQUENCY (10_000),
    .POLL_INTERVAL_MS(1),
    .SCDC_ADDRESS    (7'h54),
    .MAX_FAILURES    (MAXF)
  ) dut (
    .system_clock      (clk),
    .system_reset      (system_reset),
    .enable            (enable),
    .scrambler_expected(scrambler_expected),
    .i2c_ready         (i2c_ready),
    .i2c_address       (i2c_address),
    .i2c_rw            (i2c_rw),
    .i2c_register      (i2c_register),
    .i2c_data_write    (i2c_data_write),
    .i2c_valid         (i2c_valid),
    .i2c_nack          (i2c_nack),
    .i2c_data_read     (i2c_data_read),
    .status_valid      (status_valid),
    .clock_detected    (clock_detected),
    .ch_locked         (ch_locked),
    .scrambling_status (scrambling_status),
    .err_ch0           (err_ch0),
    .err_ch1           (err_ch1),
    .err_ch2           (err_ch2),
    .link_fault        (link_fault)
  );

  int tests = 0;
  int fails = 0;
  int next_lat;

  logic [7:0] sink [256];
  logic [7:0] reg_list [9] = '{8'h10, 8'h21, 8'h40, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};

  // Reference model of the published status.
  int exp_clk, exp_lock, exp_scr, exp_err0, exp_err1, exp_err2, exp_cnt, exp_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int err_value(input int hi, input int lo);
    return (hi >= 128) ? (hi - 128) * 256 + lo : 0;
  endfunction

  task automatic model_reset();
    exp_clk = 0; exp_lock = 0; exp_scr = 0;
    exp_err0 = 0; exp_err1 = 0; exp_err2 = 0;
    exp_cnt = 0; exp_fault = 0;
  endtask

  task automatic model_report(input bit nacked);
    bit bad;
    if (!nacked) begin
      exp_clk  = sink[8'h40] % 2;
      exp_lock = (sink[8'h40] / 2) % 8;
      exp_scr  = sink[8'h21] % 2;
      exp_err0 = err_value(sink[8'h51], sink[8'h50]);
      exp_err1 = err_value(sink[8'h53], sink[8'h52]);
      exp_err2 = err_value(sink[8'h55], sink[8'h54]);
    end
    bad = nacked || exp_clk == 0 || exp_lock != 7 || exp_scr != int'(scrambler_expected);
    exp_cnt = bad ? ((exp_cnt == 15) ? 15 : exp_cnt + 1) : 0;
    if (exp_cnt >= int'(MAXF)) exp_fault = 1;
  endtask

  task automatic check_status(input string when);
    check_eq({when, ".clock_detected"}, clock_detected, exp_clk);
    check_eq({when, ".ch_locked"}, ch_locked, exp_lock);
    check_eq({when, ".scrambling_status"}, scrambling_status, exp_scr);
    check_eq({when, ".err_ch0"}, err_ch0, exp_err0);
    check_eq({when, ".err_ch1"}, err_ch1, exp_err1);
    check_eq({when, ".err_ch2"}, err_ch2, exp_err2);
    check_eq({when, ".link_fault"}, link_fault, exp_fault);
  endtask

  // mode: 0 healthy, 1 clock lost, 2 a lane unlocked, 3 scrambler mismatch
  task automatic set_sink(input int mode);
    logic [7:0] b;
    for (int i = 0; i < 256; i++) sink[i] = 8'($urandom);
    b = 8'($urandom);
    b[3:0] = 4'hF;
    if (mode == 1) b[0] = 1'b0;
    if (mode == 2) b[3:1] = 3'($urandom_range(0, 6));
    sink[8'h40] = b;
    b = 8'($urandom);
    b[0] = (mode == 3) ? ~scrambler_expected : scrambler_expected;
    sink[8'h21] = b;
  endtask

  task automatic wait_ready(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("status_valid_one_cycle", status_valid, 0);
      if (i2c_ready) begin
        lat = i;
        ok  = 1'b1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL ready_timeout: i2c_ready still 0 after 64 cycles, expected 1");
  endtask

  // One poll. nack_at/abort_at select a transaction (0..9, 9 = clearing write); 10 = never.
  task automatic do_poll(input int nack_at, input int abort_at, input bit rst_in_clear);
    int lat;
    bit ok;
    logic [7:0] reg_e;
    wait_ready(lat, ok);
    if (!ok) return;
    check_eq("ready_latency", lat, next_lat);
    check_eq("i2c_address", i2c_address, 7'h54);
    for (int t = 0; t < 10; t++) begin
      reg_e = (t == 9) ? 8'h10 : reg_list[t];
      check_eq($sformatf("register[%0d]", t), i2c_register, reg_e);
      check_eq($sformatf("rw[%0d]", t), i2c_rw, (t == 9) ? 0 : 1);
      if (t == 9) check_eq("clear_write_data", i2c_data_write, sink[8'h10]);
      check_eq("status_valid_mid_poll", status_valid, 0);
      if (t == abort_at) begin
        enable = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", i2c_ready, 0);
        exp_cnt = 0;
        exp_fault = 0;
        repeat (5) begin
          @(negedge clk);
          check_eq("abort_no_status_valid", status_valid, 0);
        end
        check_status("abort_hold");
        enable = 1'b1;
        next_lat = 11;
        return;
      end
      if (rst_in_clear && t == 9) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        system_reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_eq("reset_ready", i2c_ready, 0);
        check_eq("reset_rw", i2c_rw, 1);
        check_eq("reset_status_valid", status_valid, 0);
        check_status("reset");
        system_reset = 1'b0;
        next_lat = 11;
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_eq("ready_held", i2c_ready, 1);
      end
      i2c_valid     = 1'b1;
      i2c_nack      = (t == nack_at);
      i2c_data_read = (t == 9) ? 8'($urandom) : sink[reg_e];
      @(negedge clk);
      i2c_valid = 1'b0;
      i2c_nack  = 1'b0;
      if (t == nack_at || t == 9) break;
    end
    check_eq("ready_dropped", i2c_ready, 0);
    check_eq("status_valid_early", status_valid, 0);
    @(negedge clk);
    check_eq("status_valid_pulse", status_valid, 1);
    model_report(nack_at <= 9);
    check_status("report");
    next_lat = 10;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, nack_at, abort_at;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_ready", i2c_ready, 0);
    check_eq("reset_rw", i2c_rw, 1);
    check_eq("reset_status_valid", status_valid, 0);
    check_status("reset");
    system_reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("idle_ready", i2c_ready, 0);

    // Healthy sink, first poll after enable.
    scrambler_expected = 1'b1;
    set_sink(0);
    sink[8'h40] = 8'h0F;
    sink[8'h21] = 8'h01;
    sink[8'h51] = 8'h00;
    sink[8'h53] = 8'h00;
    sink[8'h55] = 8'h00;
    enable   = 1'b1;
    next_lat = 11;
    do_poll(10, 10, 1'b0);
    check_eq("t1_ch_locked", ch_locked, 3'b111);
    check_eq("t1_link_fault", link_fault, 0);

    // Error counter packing and the valid bit.
    set_sink(0);
    sink[8'h50] = 8'h34; sink[8'h51] = 8'h92;
    sink[8'h52] = 8'hFF; sink[8'h53] = 8'h7F;
    do_poll(10, 10, 1'b0);
    check_eq("t2_err_ch0", err_ch0, 15'h1234);
    check_eq("t2_err_ch1", err_ch1, 15'h0000);

    // Three NACKed polls raise link_fault; a good poll leaves it set.
    for (int p = 0; p < 3; p++) begin
      set_sink(0);
      do_poll($urandom_range(0, 9), 10, 1'b0);
    end
    check_eq("t3_fault_after_3", link_fault, 1);
    set_sink(0);
    do_poll(10, 10, 1'b0);
    check_eq("t3_fault_sticky", link_fault, 1);

    // Scrambler mismatch counts; an interleaved good poll resets the count.
    set_sink(3); do_poll(10, 10, 1'b0);
    set_sink(0); do_poll(10, 10, 1'b0);
    set_sink(3); do_poll(10, 10, 1'b0);

    // Enable dropped at idx 4, then a fresh poll.
    set_sink(0); do_poll(10, 4, 1'b0);
    set_sink(0); do_poll(10, 10, 1'b0);

    // Reset asserted while the clearing write is outstanding.
    set_sink(1); do_poll(10, 10, 1'b0);
    set_sink(2); do_poll(10, 10, 1'b0);
    set_sink(0); do_poll(10, 10, 1'b1);
    set_sink(0); do_poll(10, 10, 1'b0);

    // Random polls.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 4) == 0) scrambler_expected = ~scrambler_expected;
      mode     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      nack_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : 10;
      set_sink(mode);
      do_poll(nack_at, abort_at, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
